// File: rtl/universal_reg_rs.sv
// N-bit universal register with asynchronous active-low reset and set, clock enable
// and an 8-way operation select: hold, load, shift, rotate, increment, decrement.
module universal_reg_rs #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] SET_VAL   = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             set_n,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] d,
    input  logic             sil,
    input  logic             sir,
    output logic [WIDTH-1:0] q,
    output logic             co,
    output logic             zero
);

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_SHR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;
    localparam logic [2:0] OP_INC  = 3'b110;
    localparam logic [2:0] OP_DEC  = 3'b111;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_q;
    logic             r_co;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_co_nxt;
    logic [WIDTH:0]   w_sum;
    logic             w_set_n;

    // Set is qualified by reset so that releasing reset while set is still low
    // produces a falling edge here and the register jumps to SET_VAL at once.
    assign w_set_n = set_n | ~reset_n;

    assign w_sum = {1'b0, r_q} + {1'b0, ONE};

    always_comb begin
        w_q_nxt  = r_q;
        w_co_nxt = r_co;
        if (en) begin
            case (op)
                OP_HOLD: begin
                    w_q_nxt  = r_q;
                    w_co_nxt = r_co;
                end
                OP_LOAD: begin
                    w_q_nxt  = d;
                    w_co_nxt = 1'b0;
                end
                OP_SHL: begin
                    w_q_nxt  = {r_q[WIDTH-2:0], sil};
                    w_co_nxt = r_q[WIDTH-1];
                end
                OP_SHR: begin
                    w_q_nxt  = {sir, r_q[WIDTH-1:1]};
                    w_co_nxt = r_q[0];
                end
                OP_ROL: begin
                    w_q_nxt  = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                    w_co_nxt = r_q[WIDTH-1];
                end
                OP_ROR: begin
                    w_q_nxt  = {r_q[0], r_q[WIDTH-1:1]};
                    w_co_nxt = r_q[0];
                end
                OP_INC: begin
                    w_q_nxt  = w_sum[WIDTH-1:0];
                    w_co_nxt = w_sum[WIDTH];
                end
                OP_DEC: begin
                    w_q_nxt  = r_q - ONE;
                    w_co_nxt = (r_q == {WIDTH{1'b0}});
                end
                default: begin
                    w_q_nxt  = r_q;
                    w_co_nxt = r_co;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n or negedge w_set_n) begin
        if (!reset_n) begin
            r_q  <= RESET_VAL;
            r_co <= 1'b0;
        end else if (!w_set_n) begin
            r_q  <= SET_VAL;
            r_co <= 1'b0;
        end else begin
            r_q  <= w_q_nxt;
            r_co <= w_co_nxt;
        end
    end

    assign q    = r_q;
    assign co   = r_co;
    assign zero = (r_q == {WIDTH{1'b0}});

endmodule

// File: tb/tb_universal_reg_rs.sv
// Self-checking bench for universal_reg_rs (WIDTH=8): directed scenarios plus a
// randomized run compared against an arithmetic reference model.
module tb_universal_reg_rs;

    logic       clk;
    logic       reset_n;
    logic       set_n;
    logic       en;
    logic [2:0] op;
    logic [7:0] d;
    logic       sil;
    logic       sir;
    logic [7:0] q;
    logic       co;
    logic       zero;

    int errors = 0;
    int checks = 0;

    universal_reg_rs #(
        .WIDTH    (8),
        .RESET_VAL(8'h00),
        .SET_VAL  (8'hFF)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .set_n  (set_n),
        .en     (en),
        .op     (op),
        .d      (d),
        .sil    (sil),
        .sir    (sir),
        .q      (q),
        .co     (co),
        .zero   (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One active edge, then settle 1 ns past it before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the operation rules expressed as plain integer arithmetic.
    function automatic void ref_next(input int cq, input int cc, input int e, input int o,
                                     input int dd, input int si_l, input int si_r,
                                     output int nq, output int nc);
        nq = cq;
        nc = cc;
        if (e != 0) begin
            case (o)
                0: begin nq = cq; nc = cc; end
                1: begin nq = dd; nc = 0; end
                2: begin nq = (cq * 2 + si_l) % 256; nc = (cq >= 128) ? 1 : 0; end
                3: begin nq = cq / 2 + si_r * 128; nc = cq % 2; end
                4: begin nq = (cq * 2) % 256 + cq / 128; nc = cq / 128; end
                5: begin nq = cq / 2 + (cq % 2) * 128; nc = cq % 2; end
                6: begin nq = (cq + 1) % 256; nc = (cq == 255) ? 1 : 0; end
                default: begin nq = (cq + 255) % 256; nc = (cq == 0) ? 1 : 0; end
            endcase
        end
    endfunction

    task automatic test_reset();
        #2;
        checks++;
        if (q !== 8'h00 || co !== 1'b0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL reset_both_low: q=%h co=%b zero=%b, required q=00 co=0 zero=1", q, co, zero);
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (q !== 8'hFF || co !== 1'b0 || zero !== 1'b0) begin
            errors++;
            $display("FAIL set_after_reset_release: q=%h co=%b zero=%b, required q=ff co=0 zero=0", q, co, zero);
        end
        tick();
        checks++;
        if (q !== 8'hFF) begin
            errors++;
            $display("FAIL set_held_over_edge: q=%h, required ff", q);
        end
        set_n = 1'b0;
        en    = 1'b1;
        op    = 3'b110;
        #1;
        set_n = 1'b1;
        #1;
        checks++;
        if (q !== 8'hFF || co !== 1'b0) begin
            errors++;
            $display("FAIL set_release_no_effect: q=%h co=%b, required q=ff co=0", q, co);
        end
        en = 1'b0;
        tick();
    endtask

    task automatic test_load_hold();
        en = 1'b1;
        op = 3'b001;
        d  = 8'hA5;
        tick();
        checks++;
        if (q !== 8'hA5 || co !== 1'b0) begin
            errors++;
            $display("FAIL load: q=%h co=%b, required q=a5 co=0", q, co);
        end
        en = 1'b0;
        op = 3'b110;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (q !== 8'hA5 || co !== 1'b0) begin
                errors++;
                $display("FAIL enable_low_hold[%0d]: q=%h co=%b, required q=a5 co=0", i, q, co);
            end
        end
        en = 1'b1;
        op = 3'b000;
        tick();
        checks++;
        if (q !== 8'hA5 || co !== 1'b0) begin
            errors++;
            $display("FAIL op_hold: q=%h co=%b, required q=a5 co=0", q, co);
        end
    endtask

    task automatic test_shift();
        en  = 1'b1;
        op  = 3'b010;
        sil = 1'b1;
        tick();
        checks++;
        if (q !== 8'h4B || co !== 1'b1) begin
            errors++;
            $display("FAIL shift_left: q=%h co=%b, required q=4b co=1", q, co);
        end
        op  = 3'b011;
        sir = 1'b0;
        tick();
        checks++;
        if (q !== 8'h25 || co !== 1'b1) begin
            errors++;
            $display("FAIL shift_right: q=%h co=%b, required q=25 co=1", q, co);
        end
        sir = 1'b1;
        tick();
        checks++;
        if (q !== 8'h92 || co !== 1'b1) begin
            errors++;
            $display("FAIL shift_right_sir1: q=%h co=%b, required q=92 co=1", q, co);
        end
    endtask

    task automatic test_rotate();
        en = 1'b1;
        op = 3'b001;
        d  = 8'h81;
        tick();
        op = 3'b100;
        tick();
        checks++;
        if (q !== 8'h03 || co !== 1'b1) begin
            errors++;
            $display("FAIL rotate_left: q=%h co=%b, required q=03 co=1", q, co);
        end
        op = 3'b101;
        tick();
        checks++;
        if (q !== 8'h81 || co !== 1'b1) begin
            errors++;
            $display("FAIL rotate_right: q=%h co=%b, required q=81 co=1", q, co);
        end
    endtask

    task automatic test_incdec();
        en = 1'b1;
        op = 3'b001;
        d  = 8'hFE;
        tick();
        op = 3'b110;
        tick();
        checks++;
        if (q !== 8'hFF || co !== 1'b0 || zero !== 1'b0) begin
            errors++;
            $display("FAIL inc_to_ff: q=%h co=%b zero=%b, required q=ff co=0 zero=0", q, co, zero);
        end
        tick();
        checks++;
        if (q !== 8'h00 || co !== 1'b1 || zero !== 1'b1) begin
            errors++;
            $display("FAIL inc_wrap: q=%h co=%b zero=%b, required q=00 co=1 zero=1", q, co, zero);
        end
        op = 3'b111;
        tick();
        checks++;
        if (q !== 8'hFF || co !== 1'b1) begin
            errors++;
            $display("FAIL dec_wrap: q=%h co=%b, required q=ff co=1", q, co);
        end
        tick();
        checks++;
        if (q !== 8'hFE || co !== 1'b0) begin
            errors++;
            $display("FAIL dec_plain: q=%h co=%b, required q=fe co=0", q, co);
        end
    endtask

    task automatic test_async_mid();
        en = 1'b1;
        op = 3'b001;
        d  = 8'h10;
        tick();
        op = 3'b110;
        tick();
        tick();
        checks++;
        if (q !== 8'h12) begin
            errors++;
            $display("FAIL count_before_reset: q=%h, required 12", q);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (q !== 8'h00 || co !== 1'b0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_mid: q=%h co=%b zero=%b, required q=00 co=0 zero=1", q, co, zero);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (q !== 8'h00) begin
                errors++;
                $display("FAIL reset_held[%0d]: q=%h, required 00", i, q);
            end
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (q !== 8'h00) begin
            errors++;
            $display("FAIL reset_release_no_effect: q=%h, required 00", q);
        end
        tick();
        checks++;
        if (q !== 8'h01 || co !== 1'b0) begin
            errors++;
            $display("FAIL count_resume: q=%h co=%b, required q=01 co=0", q, co);
        end
    endtask

    task automatic test_random();
        int mq;
        int mc;
        int nq;
        int nc;
        int kind;
        en = 1'b1;
        op = 3'b001;
        d  = 8'h3C;
        tick();
        mq = 8'h3C;
        mc = 0;
        for (int i = 0; i < 400; i++) begin
            kind = $urandom_range(0, 19);
            if (kind == 0) begin
                reset_n = 1'b0;
                #1;
                mq = 0;
                mc = 0;
                checks++;
                if (q !== 8'(mq) || co !== 1'b0 || zero !== 1'b1) begin
                    errors++;
                    $display("FAIL rand_reset[%0d]: q=%h co=%b zero=%b, required q=00 co=0 zero=1", i, q, co, zero);
                end
                reset_n = 1'b1;
            end else if (kind == 1) begin
                set_n = 1'b0;
                #1;
                mq = 255;
                mc = 0;
                checks++;
                if (q !== 8'(mq) || co !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_set[%0d]: q=%h co=%b, required q=ff co=0", i, q, co);
                end
                set_n = 1'b1;
            end
            en  = ($urandom_range(0, 3) != 0);
            op  = 3'($urandom_range(0, 7));
            d   = 8'($urandom_range(0, 255));
            sil = 1'($urandom_range(0, 1));
            sir = 1'($urandom_range(0, 1));
            ref_next(mq, mc, int'(en), int'(op), int'(d), int'(sil), int'(sir), nq, nc);
            tick();
            mq = nq;
            mc = nc;
            checks++;
            if (q !== 8'(mq) || co !== 1'(mc) || zero !== (mq == 0)) begin
                errors++;
                $display("FAIL rand_step[%0d] en=%b op=%0d: q=%h co=%b zero=%b, required q=%h co=%0d zero=%0d",
                         i, en, op, q, co, zero, mq[7:0], mc, (mq == 0));
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        set_n   = 1'b0;
        en      = 1'b0;
        op      = 3'b000;
        d       = 8'h00;
        sil     = 1'b0;
        sir     = 1'b0;
        test_reset();
        test_load_hold();
        test_shift();
        test_rotate();
        test_incdec();
        test_async_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
